directory_controller: RTL and testbench

- Home-node directory for the two-processor coherence system; sits on the other end of the L1 interconnect.
- Consumes read-miss / write-miss / invalidate messages from cache C0 and cache C1.
- Owns the backing memory and a full-map directory (state + 2-bit sharer mask per block).
- Issues fetch / invalidate / fetch-invalidate to remote caches, collects write-backs, and returns data replies to the requester.

---
 rtl/directory_controller_if.sv | 37 +++
 rtl/directory_controller.sv | 209 ++++++++++++++++++++
 tb/tb_directory_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/directory_controller_if.sv
// Signal bundle between the two L1 caches and the home-node directory controller.
interface directory_controller_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [2:0]        msg_c0;
    logic [ADDR_W-1:0] addr_c0;
    logic [2:0]        msg_c1;
    logic [ADDR_W-1:0] addr_c1;
    logic              wb_valid_c0;
    logic [DATA_W-1:0] wb_data_c0;
    logic              wb_valid_c1;
    logic [DATA_W-1:0] wb_data_c1;
    logic [2:0]        msg_to_c0;
    logic [2:0]        msg_to_c1;
    logic [ADDR_W-1:0] addr_to_c;
    logic              ack_c0;
    logic              ack_c1;
    logic              data_reply_c0;
    logic              data_reply_c1;
    logic [DATA_W-1:0] reply_data;
    logic              err;

    modport master (
        output msg_c0, addr_c0, msg_c1, addr_c1,
        output wb_valid_c0, wb_data_c0, wb_valid_c1, wb_data_c1,
        input  msg_to_c0, msg_to_c1, addr_to_c, ack_c0, ack_c1,
        input  data_reply_c0, data_reply_c1, reply_data, err
    );

    modport slave (
        input  msg_c0, addr_c0, msg_c1, addr_c1,
        input  wb_valid_c0, wb_data_c0, wb_valid_c1, wb_data_c1,
        output msg_to_c0, msg_to_c1, addr_to_c, ack_c0, ack_c1,
        output data_reply_c0, data_reply_c1, reply_data, err
    );
endinterface

// File: rtl/directory_controller.sv
// Home-node full-map directory for two caches: arbitrates misses/upgrades, drives
// remote fetch/invalidate, collects write-backs and replies to the requester.
module directory_controller #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int WB_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    directory_controller_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, SEND, WAIT_WB, REPLY} fsm_t;
    typedef enum logic [1:0] {DIR_U = 2'b00, DIR_S = 2'b01, DIR_E = 2'b10} dir_t;

    localparam logic [2:0] MSG_RD  = 3'b100;
    localparam logic [2:0] MSG_INV = 3'b001;
    localparam logic [2:0] TO_FETCH = 3'b100;
    localparam logic [2:0] TO_INV   = 3'b010;
    localparam logic [2:0] TO_FINV  = 3'b001;

    fsm_t              state;
    dir_t              dir_state   [DEPTH];
    logic [1:0]        dir_sharers [DEPTH];
    logic              written     [DEPTH];
    logic [DATA_W-1:0] mem         [DEPTH];

    logic              rr_ptr;
    logic              req_id;
    logic [2:0]        req_msg;
    logic [ADDR_W-1:0] req_addr;
    dir_t              nxt_state;
    logic [1:0]        nxt_sharers;
    logic              with_data;
    logic              need_wb;
    logic [3:0]        wb_cnt;

    logic              valid0, valid1, grant;
    logic [2:0]        grant_msg;
    logic [ADDR_W-1:0] grant_addr;
    dir_t              cur_state;
    logic [1:0]        cur_sharers, bit_i, bit_j;
    logic              has_i, has_j;
    logic              wb_accept;
    logic [DATA_W-1:0] wb_sel_data, rd_data;
    logic [2:0]        dec_remote;
    dir_t              dec_state;
    logic [1:0]        dec_sharers;
    logic              dec_data, dec_wb, dec_err;

    always_comb begin
        // NOTE: every combinational signal gets a default first so no path can infer a latch.
        // A cache whose ack is still on the wire has not yet dropped its level request.
        valid0      = (bus.msg_c0 != 3'b000) && !bus.ack_c0;
        valid1      = (bus.msg_c1 != 3'b000) && !bus.ack_c1;
        grant       = (valid0 && valid1) ? rr_ptr : valid1;
        grant_msg   = grant ? bus.msg_c1  : bus.msg_c0;
        grant_addr  = grant ? bus.addr_c1 : bus.addr_c0;
        cur_state   = dir_state[req_addr];
        cur_sharers = dir_sharers[req_addr];
        bit_i       = req_id ? 2'b10 : 2'b01;
        bit_j       = ~bit_i;
        has_i       = (cur_sharers & bit_i) != 2'b00;
        has_j       = (cur_sharers & bit_j) != 2'b00;
        wb_accept   = !reset && (state == WAIT_WB) && (req_id ? bus.wb_valid_c0 : bus.wb_valid_c1);
        wb_sel_data = req_id ? bus.wb_data_c0 : bus.wb_data_c1;
        rd_data     = written[req_addr] ? mem[req_addr] : DATA_W'(req_addr);
    end

    always_comb begin
        dec_remote  = 3'b000;
        dec_state   = DIR_S;
        dec_sharers = bit_i;
        dec_data    = 1'b1;
        dec_wb      = 1'b0;
        dec_err     = 1'b0;
        if (req_msg == MSG_RD) begin
            case (cur_state)
                DIR_S: dec_sharers = cur_sharers | bit_i;
                DIR_E: begin
                    if (has_j) begin
                        dec_remote  = TO_FETCH;
                        dec_sharers = 2'b11;
                        dec_wb      = 1'b1;
                    end else begin
                        dec_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            // A lost upgrade race falls through here and is treated as a write miss.
            dec_state = DIR_E;
            if (cur_state == DIR_S) begin
                dec_data = !((req_msg == MSG_INV) && has_i);
                if (has_j) dec_remote = TO_INV;
            end else if ((cur_state == DIR_E) && has_j) begin
                dec_remote = TO_FINV;
                dec_wb     = 1'b1;
            end
        end
    end

    // NOTE: memory array is deliberately not reset; the reset-cleared written flags make an untouched block read back its initial image.
    always_ff @(posedge clk) begin
        if (wb_accept) mem[req_addr] <= wb_sel_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            rr_ptr            <= 1'b0;
            req_id            <= 1'b0;
            req_msg           <= 3'b000;
            req_addr          <= '0;
            nxt_state         <= DIR_U;
            nxt_sharers       <= 2'b00;
            with_data         <= 1'b0;
            need_wb           <= 1'b0;
            wb_cnt            <= 4'd0;
            bus.msg_to_c0     <= 3'b000;
            bus.msg_to_c1     <= 3'b000;
            bus.addr_to_c     <= '0;
            bus.ack_c0        <= 1'b0;
            bus.ack_c1        <= 1'b0;
            bus.data_reply_c0 <= 1'b0;
            bus.data_reply_c1 <= 1'b0;
            bus.reply_data    <= '0;
            bus.err           <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                dir_state[k]   <= DIR_U;
                dir_sharers[k] <= 2'b00;
                written[k]     <= 1'b0;
            end
        end else begin
            bus.msg_to_c0     <= 3'b000;
            bus.msg_to_c1     <= 3'b000;
            bus.addr_to_c     <= '0;
            bus.ack_c0        <= 1'b0;
            bus.ack_c1        <= 1'b0;
            bus.data_reply_c0 <= 1'b0;
            bus.data_reply_c1 <= 1'b0;
            bus.reply_data    <= '0;
            bus.err           <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid0 || valid1) begin
                        if (valid0 && valid1) rr_ptr <= ~grant;
                        if ((grant_msg & (grant_msg - 3'd1)) != 3'b000) begin
                            bus.err <= 1'b1;
                            if (grant) bus.ack_c1 <= 1'b1;
                            else       bus.ack_c0 <= 1'b1;
                        end else begin
                            req_id   <= grant;
                            req_msg  <= grant_msg;
                            req_addr <= grant_addr;
                            state    <= LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    nxt_state   <= dec_state;
                    nxt_sharers <= dec_sharers;
                    with_data   <= dec_data;
                    need_wb     <= dec_wb;
                    wb_cnt      <= 4'd0;
                    bus.err     <= dec_err;
                    if (dec_remote != 3'b000) begin
                        if (req_id) bus.msg_to_c0 <= dec_remote;
                        else        bus.msg_to_c1 <= dec_remote;
                        bus.addr_to_c <= req_addr;
                        state         <= SEND;
                    end else begin
                        state <= REPLY;
                    end
                end
                SEND: state <= need_wb ? WAIT_WB : REPLY;
                WAIT_WB: begin
                    if (wb_accept) begin
                        written[req_addr] <= 1'b1;
                        state             <= REPLY;
                    end else if (wb_cnt == 4'(WB_TIMEOUT - 1)) begin
                        bus.err <= 1'b1;
                        state   <= REPLY;
                    end else begin
                        wb_cnt <= wb_cnt + 4'd1;
                    end
                end
                REPLY: begin
                    dir_state[req_addr]   <= nxt_state;
                    dir_sharers[req_addr] <= nxt_sharers;
                    if (req_id) begin
                        bus.ack_c1        <= 1'b1;
                        bus.data_reply_c1 <= with_data;
                    end else begin
                        bus.ack_c0        <= 1'b1;
                        bus.data_reply_c0 <= with_data;
                    end
                    bus.reply_data <= rd_data;
                    bus.addr_to_c  <= req_addr;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_directory_controller.sv
// Directed bench for directory_controller: each step drives cache requests and
// compares latency, reply, remote messages and directory entries with hand values.
module tb_directory_controller;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    directory_controller_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    directory_controller #(.ADDR_W(8), .DATA_W(8), .WB_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dir(input string tag, input logic [7:0] a,
                             input logic [1:0] st, input logic [1:0] sh);
        check({tag, ".state"},   32'(dut.dir_state[a]),   32'(st));
        check({tag, ".sharers"}, 32'(dut.dir_sharers[a]), 32'(sh));
    endtask

    // One request from cache cid; latency counted from the IDLE capture edge.
    task automatic do_req(input bit cid, input logic [2:0] msg, input logic [7:0] addr,
                          input int wb_after, input logic [7:0] wb_val,
                          output int lat, output logic dr, output logic [7:0] rd,
                          output logic [2:0] remote, output int errs, output int other_acks);
        int  t_remote;
        bit  done;
        lat = -1; dr = 1'b0; rd = 8'h00; remote = 3'b000;
        errs = 0; other_acks = 0; t_remote = -1; done = 1'b0;
        if (cid) begin bus.msg_c1 = msg; bus.addr_c1 = addr; end
        else     begin bus.msg_c0 = msg; bus.addr_c0 = addr; end
        for (int t = 1; t <= 60 && !done; t++) begin
            tick();
            if (cid) bus.wb_valid_c0 = 1'b0;
            else     bus.wb_valid_c1 = 1'b0;
            if (t_remote < 0 && (cid ? bus.msg_to_c0 : bus.msg_to_c1) != 3'b000) begin
                remote   = cid ? bus.msg_to_c0 : bus.msg_to_c1;
                t_remote = t;
            end
            if (bus.err) errs++;
            if (cid ? bus.ack_c0 : bus.ack_c1) other_acks++;
            if (cid ? bus.ack_c1 : bus.ack_c0) begin
                lat  = t - 1;
                dr   = cid ? bus.data_reply_c1 : bus.data_reply_c0;
                rd   = bus.reply_data;
                done = 1'b1;
            end
            if (wb_after >= 0 && t_remote >= 0 && t == t_remote + wb_after) begin
                if (cid) begin bus.wb_valid_c0 = 1'b1; bus.wb_data_c0 = wb_val; end
                else     begin bus.wb_valid_c1 = 1'b1; bus.wb_data_c1 = wb_val; end
            end
        end
        if (cid) bus.msg_c1 = 3'b000;
        else     bus.msg_c0 = 3'b000;
        tick();
    endtask

    // Both caches issue read_miss to the same block in the same cycle.
    task automatic race(input logic [7:0] addr, output int t0, output int t1,
                        output int n0, output int n1, output logic [7:0] rd0, output logic [7:0] rd1);
        t0 = -1; t1 = -1; n0 = 0; n1 = 0; rd0 = 8'h00; rd1 = 8'h00;
        bus.msg_c0 = 3'b100; bus.addr_c0 = addr;
        bus.msg_c1 = 3'b100; bus.addr_c1 = addr;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (bus.ack_c0) begin n0++; if (t0 < 0) t0 = t; rd0 = bus.reply_data; bus.msg_c0 = 3'b000; end
            if (bus.ack_c1) begin n1++; if (t1 < 0) t1 = t; rd1 = bus.reply_data; bus.msg_c1 = 3'b000; end
        end
        bus.msg_c0 = 3'b000;
        bus.msg_c1 = 3'b000;
        tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int         lat, errs, oacks, t0, t1, n0, n1, acks;
        logic       dr, seen;
        logic [7:0] rd, rd0, rd1;
        logic [2:0] remote;

        reset = 1'b1;
        bus.msg_c0 = 3'b000; bus.addr_c0 = 8'h00;
        bus.msg_c1 = 3'b000; bus.addr_c1 = 8'h00;
        bus.wb_valid_c0 = 1'b0; bus.wb_data_c0 = 8'h00;
        bus.wb_valid_c1 = 1'b0; bus.wb_data_c1 = 8'h00;
        apply_reset();

        check("reset.outputs", 32'({bus.msg_to_c0, bus.msg_to_c1, bus.addr_to_c, bus.ack_c0, bus.ack_c1,
                                    bus.data_reply_c0, bus.data_reply_c1, bus.reply_data, bus.err}), 32'd0);
        check_dir("reset.dir05", 8'h05, 2'b00, 2'b00);

        // C0 read_miss to an uncached block
        do_req(1'b0, 3'b100, 8'h05, -1, 8'h00, lat, dr, rd, remote, errs, oacks);
        check("rd_u.lat", 32'(lat), 32'd2);
        check("rd_u.data_reply", 32'(dr), 32'd1);
        check("rd_u.reply_data", 32'(rd), 32'h05);
        check("rd_u.remote", 32'(remote), 32'd0);
        check_dir("rd_u.dir", 8'h05, 2'b01, 2'b01);

        // C0 write_miss, C1 not a sharer: no remote message
        do_req(1'b0, 3'b010, 8'h05, -1, 8'h00, lat, dr, rd, remote, errs, oacks);
        check("wr_s.lat", 32'(lat), 32'd2);
        check("wr_s.remote", 32'(remote), 32'd0);
        check_dir("wr_s.dir", 8'h05, 2'b10, 2'b01);

        // C1 read_miss to block owned by C0: fetch, write-back 3 cycles after the pulse
        do_req(1'b1, 3'b100, 8'h05, 3, 8'hAA, lat, dr, rd, remote, errs, oacks);
        check("rd_e.remote", 32'(remote), 32'b100);
        check("rd_e.lat", 32'(lat), 32'd6);
        check("rd_e.reply_data", 32'(rd), 32'hAA);
        check("rd_e.data_reply", 32'(dr), 32'd1);
        check("rd_e.other_acks", 32'(oacks), 32'd0);
        check("rd_e.mem", 32'(dut.mem[8'h05]), 32'hAA);
        check_dir("rd_e.dir", 8'h05, 2'b01, 2'b11);

        // C1 upgrade while shared with C0: invalidate C0, ack without data
        do_req(1'b1, 3'b001, 8'h05, -1, 8'h00, lat, dr, rd, remote, errs, oacks);
        check("upg.remote", 32'(remote), 32'b010);
        check("upg.lat", 32'(lat), 32'd3);
        check("upg.data_reply", 32'(dr), 32'd0);
        check_dir("upg.dir", 8'h05, 2'b10, 2'b10);

        // C1 takes 0x10 exclusive, then C0 write_miss with no write-back: timeout
        do_req(1'b1, 3'b010, 8'h10, -1, 8'h00, lat, dr, rd, remote, errs, oacks);
        check("own10.reply_data", 32'(rd), 32'h10);
        check_dir("own10.dir", 8'h10, 2'b10, 2'b10);
        bus.wb_valid_c0 = 1'b1;
        bus.wb_data_c0  = 8'h77;
        do_req(1'b0, 3'b010, 8'h10, -1, 8'h00, lat, dr, rd, remote, errs, oacks);
        bus.wb_valid_c0 = 1'b0;
        check("tmo.remote", 32'(remote), 32'b001);
        check("tmo.lat", 32'(lat), 32'd18);
        check("tmo.err_count", 32'(errs), 32'd1);
        check("tmo.reply_data", 32'(rd), 32'h10);
        check("tmo.data_reply", 32'(dr), 32'd1);
        check_dir("tmo.dir", 8'h10, 2'b10, 2'b01);

        // Simultaneous requests after reset: C0 first, then pointer favours C1
        apply_reset();
        race(8'h20, t0, t1, n0, n1, rd0, rd1);
        check("race1.t0", 32'(t0), 32'd3);
        check("race1.t1", 32'(t1), 32'd6);
        check("race1.acks", 32'({n0[7:0], n1[7:0]}), 32'h0101);
        check("race1.rd1", 32'(rd1), 32'h20);
        check_dir("race1.dir", 8'h20, 2'b01, 2'b11);
        race(8'h21, t0, t1, n0, n1, rd0, rd1);
        check("race2.t1", 32'(t1), 32'd3);
        check("race2.t0", 32'(t0), 32'd6);
        check("race2.acks", 32'({n0[7:0], n1[7:0]}), 32'h0101);

        // Malformed message: err plus immediate ack, directory untouched
        do_req(1'b0, 3'b110, 8'h30, -1, 8'h00, lat, dr, rd, remote, errs, oacks);
        check("bad.lat", 32'(lat), 32'd0);
        check("bad.err_count", 32'(errs), 32'd1);
        check("bad.data_reply", 32'(dr), 32'd0);
        check_dir("bad.dir", 8'h30, 2'b00, 2'b00);

        // Reset while waiting for a write-back
        do_req(1'b1, 3'b010, 8'h40, -1, 8'h00, lat, dr, rd, remote, errs, oacks);
        check_dir("own40.dir", 8'h40, 2'b10, 2'b10);
        acks = 0;
        seen = 1'b0;
        bus.msg_c0 = 3'b100; bus.addr_c0 = 8'h40;
        for (int t = 0; t < 10 && !seen; t++) begin
            tick();
            if (bus.msg_to_c1 == 3'b100) seen = 1'b1;
            if (bus.ack_c0 || bus.ack_c1) acks++;
        end
        check("rstmid.fetch_seen", 32'(seen), 32'd1);
        for (int t = 0; t < 3; t++) begin
            tick();
            if (bus.ack_c0 || bus.ack_c1) acks++;
        end
        reset = 1'b1;
        bus.msg_c0 = 3'b000;
        for (int t = 0; t < 7; t++) begin
            tick();
            if (t == 1) reset = 1'b0;
            if (bus.ack_c0 || bus.ack_c1) acks++;
        end
        check("rstmid.no_ack", 32'(acks), 32'd0);
        check_dir("rstmid.dir40", 8'h40, 2'b00, 2'b00);
        check_dir("rstmid.dir05", 8'h05, 2'b00, 2'b00);
        do_req(1'b0, 3'b100, 8'h41, -1, 8'h00, lat, dr, rd, remote, errs, oacks);
        check("post.lat", 32'(lat), 32'd2);
        check("post.reply_data", 32'(rd), 32'h41);
        check_dir("post.dir", 8'h41, 2'b01, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
